// File: rtl/tff_count_ctrl.sv
// Sequencer for a bank of WIDTH T-flip-flops that counts up/down between 0 and a latched limit.
// Optional macro TFF_COUNT_CTRL_WRAP_EN: reload at terminal and keep running until abort.
module tff_count_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic             r_done;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_t_vec;
  logic             w_term;
  logic             w_done_nxt;

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic acc;
    acc    = 1'b1;
    w_step = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_step[i] = acc;
      acc       = acc & (r_dir ? ~r_q[i] : r_q[i]);
    end
  end

  assign w_term = r_dir ? (r_q == '0) : (r_q == r_limit);

  // Priority inside RUN: abort, then terminal, then pause, then step.
  always_comb begin
    w_next     = r_state;
    w_t_vec    = '0;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_t_vec = r_q ^ (dir ? limit : '0);
          w_next  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_term) begin
          w_done_nxt = 1'b1;
`ifdef TFF_COUNT_CTRL_WRAP_EN
          w_t_vec = r_q ^ (r_dir ? r_limit : '0);
`else
          w_next  = IDLE;
`endif
        end else if (pause) begin
          w_next = PAUSE;
        end else begin
          w_t_vec = w_step;
        end
      end
      PAUSE: begin
        if (abort) begin
          w_next = IDLE;
        end else if (!pause) begin
          w_next = RUN;
        end
      end
      default: w_next = IDLE;
    endcase
    if (!rst_n) begin
      w_t_vec = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_dir   <= 1'b0;
      r_limit <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_q     <= r_q ^ w_t_vec;
      r_done  <= w_done_nxt;
      if (r_state == IDLE && start) begin
        r_dir   <= dir;
        r_limit <= limit;
      end
    end
  end

  assign t_vec = w_t_vec;
  assign q     = r_q;
  assign qb    = ~r_q;
  assign busy  = (r_state != IDLE);
  assign done  = r_done;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl (WIDTH=4, default terminal behaviour) with an expectation queue.
module tb_tff_count_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dir;
  logic [3:0] limit;
  logic       pause;
  logic       abort;
  logic [3:0] t_vec;
  logic [3:0] q;
  logic [3:0] qb;
  logic       busy;
  logic       done;

  typedef struct {
    logic [3:0] q;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dir   (dir),
    .limit (limit),
    .pause (pause),
    .abort (abort),
    .t_vec (t_vec),
    .q     (q),
    .qb    (qb),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tvec(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, t_vec, exp);
  endtask

  // Queue the expectation for the coming edge, then compare what the DUT shows after it.
  task automatic step(input logic [3:0] eq, input logic ed, input logic eb);
    exp_t e;
    sb.push_back('{q: eq, done: ed, busy: eb});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("q", q, e.q);
      chk("qb", qb, ~e.q);
      chk("done", {3'b0, done}, {3'b0, e.done});
      chk("busy", {3'b0, busy}, {3'b0, e.busy});
    end
  endtask

  task automatic count(input int from, input int to, input logic down);
    int v;
    v = from;
    while (1) begin
      step(4'(v), 1'b0, 1'b1);
      if (v == to) break;
      v = down ? v - 1 : v + 1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    dir   = 1'b1;
    limit = 4'd9;
    pause = 1'b0;
    abort = 1'b0;

    // reset state, with start asserted to show t_vec is forced low
    #3;
    chk("rst_q", q, 4'h0);
    chk("rst_qb", qb, 4'hF);
    chk("rst_done", {3'b0, done}, 4'h0);
    chk("rst_busy", {3'b0, busy}, 4'h0);
    chk("rst_tvec", t_vec, 4'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_q", q, 4'h0);
    start = 1'b0;
    rst_n = 1'b1;

    // up, limit 5
    start = 1'b1; dir = 1'b0; limit = 4'd5;
    chk_tvec("up_load_tvec", 4'h0);
    step(4'd0, 1'b0, 1'b1);
    start = 1'b0;
    chk_tvec("up_first_tvec", 4'h1);
    count(1, 5, 1'b0);
    chk_tvec("up_term_tvec", 4'h0);
    step(4'd5, 1'b1, 1'b0);
    step(4'd5, 1'b0, 1'b0);

    // down, limit 9
    start = 1'b1; dir = 1'b1; limit = 4'd9;
    chk_tvec("dn_load_tvec", 4'hC);
    step(4'd9, 1'b0, 1'b1);
    start = 1'b0;
    step(4'd8, 1'b0, 1'b1);
    chk_tvec("dn_q8_tvec", 4'hF);
    count(7, 0, 1'b1);
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);

    // up, limit 15, pause three cycles at q=7; start during pause ignored
    start = 1'b1; dir = 1'b0; limit = 4'd15;
    step(4'd0, 1'b0, 1'b1);
    start = 1'b0;
    count(1, 7, 1'b0);
    pause = 1'b1; start = 1'b1; dir = 1'b1; limit = 4'd3;
    chk_tvec("pause_tvec", 4'h0);
    step(4'd7, 1'b0, 1'b1);
    step(4'd7, 1'b0, 1'b1);
    step(4'd7, 1'b0, 1'b1);
    pause = 1'b0; start = 1'b0;
    step(4'd7, 1'b0, 1'b1);
    count(8, 15, 1'b0);
    step(4'd15, 1'b1, 1'b0);
    step(4'd15, 1'b0, 1'b0);

    // up, limit 10, start held during run, abort at q=4
    start = 1'b1; dir = 1'b0; limit = 4'd10;
    chk_tvec("reload_tvec", 4'hF);
    step(4'd0, 1'b0, 1'b1);
    dir = 1'b1; limit = 4'd3;
    count(1, 4, 1'b0);
    start = 1'b0; abort = 1'b1;
    chk_tvec("abort_tvec", 4'h0);
    step(4'd4, 1'b0, 1'b0);
    step(4'd4, 1'b0, 1'b0);

    // start and abort together in IDLE: start wins; reset mid-run at q=6
    start = 1'b1; dir = 1'b0; limit = 4'd8;
    step(4'd0, 1'b0, 1'b1);
    start = 1'b0; abort = 1'b0;
    count(1, 6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q, 4'h0);
    chk("arst_qb", qb, 4'hF);
    chk("arst_done", {3'b0, done}, 4'h0);
    chk("arst_busy", {3'b0, busy}, 4'h0);
    chk("arst_tvec", t_vec, 4'h0);
    #1;
    rst_n = 1'b1;

    // limit 0: load, then terminal on the next edge
    start = 1'b1; dir = 1'b0; limit = 4'd0;
    step(4'd0, 1'b0, 1'b1);
    start = 1'b0;
    chk_tvec("zero_term_tvec", 4'h0);
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
